// File: rtl/companion_stat_engine.sv
// Companion status engine: NUM_STATS care stats plus health, decaying on a shared
// one-second tick, with saturating refresh, health regen/decay, alerts and latched death.
module companion_stat_engine #(
    parameter int unsigned CLOCK_FREQ    = 125_000_000,
    parameter int unsigned NUM_STATS     = 3,
    parameter int unsigned STAT_W        = 4,
    parameter int unsigned STAT_MAX      = 10,
    parameter int unsigned REFRESH_STEP  = 10,
    parameter int unsigned PERIOD_W      = 16,
    parameter int unsigned HEALTH_PERIOD = 300,
    parameter int unsigned ALERT_LEVEL   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_STATS-1:0]          action,
    input  logic [NUM_STATS*PERIOD_W-1:0] decay_period,
    input  logic                          pause,
    output logic [NUM_STATS*STAT_W-1:0]   stats,
    output logic [STAT_W-1:0]             health,
    output logic [NUM_STATS-1:0]          alert,
    output logic                          dead,
    output logic                          sec_tick
);

    localparam int unsigned PRESC_W = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam int unsigned HCNT_W  = (HEALTH_PERIOD > 1) ? $clog2(HEALTH_PERIOD + 1) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLOCK_FREQ - 1);
    localparam logic [HCNT_W-1:0]  HCNT_LAST  = HCNT_W'(HEALTH_PERIOD - 1);
    localparam logic [STAT_W-1:0]  S_MAX      = STAT_W'(STAT_MAX);
    localparam logic [STAT_W-1:0]  S_ALERT    = STAT_W'(ALERT_LEVEL);
    localparam logic [STAT_W:0]    S_MAX_X    = (STAT_W + 1)'(STAT_MAX);
    localparam logic [STAT_W:0]    S_STEP_X   = (STAT_W + 1)'(REFRESH_STEP);

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                tick_q, tick_d;
    logic [STAT_W-1:0]   stat_q [NUM_STATS];
    logic [STAT_W-1:0]   stat_d [NUM_STATS];
    logic [PERIOD_W-1:0] cnt_q  [NUM_STATS];
    logic [PERIOD_W-1:0] cnt_d  [NUM_STATS];
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic [STAT_W-1:0]   health_q, health_d;
    logic                dead_q, dead_d;

    logic                tick_en;
    logic                starving;
    logic                thriving;

    // Free-running second prescaler; keeps running while dead, holds while paused
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (!pause) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    assign tick_en = tick_q & ~pause;

    always_comb begin
        starving = 1'b0;
        thriving = 1'b1;
        for (int i = 0; i < int'(NUM_STATS); i++) begin
            if (stat_q[i] == '0)    starving = 1'b1;
            if (stat_q[i] != S_MAX) thriving = 1'b0;
        end
    end

    // Per-channel decay/refresh and health regulation; everything freezes once dead
    always_comb begin
        logic [PERIOD_W-1:0] period;
        logic [STAT_W:0]     sum;
        period   = '0;
        sum      = '0;
        stat_d   = stat_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        health_d = health_q;
        dead_d   = dead_q | (health_q == '0);
        if (!dead_q) begin
            for (int i = 0; i < int'(NUM_STATS); i++) begin
                period = decay_period[i*PERIOD_W +: PERIOD_W];
                if (action[i]) begin
                    sum       = {1'b0, stat_q[i]} + S_STEP_X;
                    stat_d[i] = (sum > S_MAX_X) ? S_MAX : sum[STAT_W-1:0];
                    cnt_d[i]  = '0;
                end else if (period == '0) begin
                    cnt_d[i] = '0;
                end else if (tick_en) begin
                    // >= catches a period lowered below the running count
                    if (cnt_q[i] >= period - PERIOD_W'(1)) begin
                        cnt_d[i] = '0;
                        if (stat_q[i] != '0) stat_d[i] = stat_q[i] - STAT_W'(1);
                    end else begin
                        cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
                    end
                end
            end

            if (!(starving || thriving)) begin
                hcnt_d = '0;
            end else if (tick_en) begin
                if (hcnt_q >= HCNT_LAST) begin
                    hcnt_d = '0;
                    if (starving) begin
                        if (health_q != '0) health_d = health_q - STAT_W'(1);
                    end else if (health_q != S_MAX) begin
                        health_d = health_q + STAT_W'(1);
                    end
                end else begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            tick_q   <= 1'b0;
            hcnt_q   <= '0;
            health_q <= S_MAX;
            dead_q   <= 1'b0;
            for (int i = 0; i < int'(NUM_STATS); i++) begin
                stat_q[i] <= S_MAX;
                cnt_q[i]  <= '0;
            end
        end else begin
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            hcnt_q   <= hcnt_d;
            health_q <= health_d;
            dead_q   <= dead_d;
            for (int i = 0; i < int'(NUM_STATS); i++) begin
                stat_q[i] <= stat_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_STATS); i++) begin
            stats[i*STAT_W +: STAT_W] = stat_q[i];
            alert[i]                  = (stat_q[i] <= S_ALERT);
        end
    end

    assign health   = health_q;
    assign dead     = dead_q;
    assign sec_tick = tick_q;

endmodule
